// File: rtl/clk_phase_sequencer.sv
// Multicycle phase sequencer: one-hot stage enables per instruction,
// programmable ticks per phase, run/step/halt control and stall handshake.
module clk_phase_sequencer #(
  parameter int NUM_PHASES = 5,
  parameter int DIV_W      = 4,
  parameter int CNT_W      = 32
) (
  input  logic                          Clk,
  input  logic                          Reset,
  input  logic                          Run,
  input  logic                          Step,
  input  logic                          Halt_Req,
  input  logic [DIV_W-1:0]              Div,
  input  logic                          Stall,
  output logic [NUM_PHASES-1:0]         Phase_En,
  output logic [$clog2(NUM_PHASES)-1:0] Phase_Idx,
  output logic                          Instr_Done,
  output logic                          Busy,
  output logic [1:0]                    State,
  output logic [CNT_W-1:0]              Instr_Count
);

  localparam int IW = $clog2(NUM_PHASES);
  localparam logic [IW-1:0] LAST = IW'(NUM_PHASES - 1);
  localparam logic [NUM_PHASES-1:0] ONE = 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    STEP    = 2'd2,
    HALTING = 2'd3
  } state_t;

  state_t           st;
  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_l;
  logic             halt_f;
  logic             fire;

  assign fire       = (st != IDLE) && (cnt == div_l) && !Stall;
  assign Phase_En   = fire ? (ONE << Phase_Idx) : '0;
  assign Instr_Done = fire && (Phase_Idx == LAST);
  assign Busy       = (st != IDLE);
  assign State      = st;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      st          <= IDLE;
      cnt         <= '0;
      Phase_Idx   <= '0;
      div_l       <= '0;
      Instr_Count <= '0;
      halt_f      <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          cnt       <= '0;
          Phase_Idx <= '0;
          // a requested halt keeps Run from restarting until Run drops
          if (Run && !halt_f) begin
            st    <= RUN;
            div_l <= Div;
          end else if (Step) begin
            st    <= STEP;
            div_l <= Div;
          end
          if (!Run)
            halt_f <= 1'b0;
        end
        default: begin
          if (fire) begin
            cnt       <= '0;
            Phase_Idx <= (Phase_Idx == LAST) ? '0 : Phase_Idx + 1'b1;
          end else if (cnt < div_l) begin
            cnt <= cnt + 1'b1;
          end
          if (Instr_Done) begin
            Instr_Count <= Instr_Count + 1'b1;
            if (st == RUN && Run && !Halt_Req) begin
              div_l <= Div;
            end else begin
              st <= IDLE;
              if (st == RUN && Halt_Req)
                halt_f <= 1'b1;
            end
          end else if (st == RUN && (Halt_Req || !Run)) begin
            st     <= HALTING;
            halt_f <= Halt_Req;
          end
        end
      endcase
    end
  end

endmodule

// File: doc/clk_phase_sequencer.md
Name: clk_phase_sequencer

Overview:
Multicycle control sequencer driven by the single system clock `Clk`. It splits each instruction into NUM_PHASES stages (fetch, decode, execute, memory, writeback) and issues one-hot, single-cycle stage-enable pulses to the datapath. Each pulse occurs after a programmable number of clock ticks. It supports run, single-step and halt control, plus a datapath stall handshake. It sits between the top-level control inputs and the datapath's register-load enables.

Parameters:
NUM_PHASES, 5, number of stages per instruction (≥2).
DIV_W, 4, width of the per-phase tick divider field.
CNT_W, 32, width of the retired-instruction counter.

Ports:
Clk  input  1  system clock; all state updates on rising edge.
Reset  input  1  synchronous, active-high reset.
Run  input  1  level; keep executing instructions while high.
Step  input  1  single-cycle pulse; execute exactly one instruction from IDLE.
Halt_Req  input  1  pulse; stop after the current instruction completes.
Div  input  DIV_W  ticks per phase minus 1; latched at each instruction start.
Stall  input  1  datapath not ready; withholds the pending phase enable.
Phase_En  output  NUM_PHASES  one-hot stage enable, high for one cycle.
Phase_Idx  output  clog2(NUM_PHASES)  current phase index.
Instr_Done  output  1  high in the same cycle as the last-phase enable.
Busy  output  1  high when State != IDLE.
State  output  2  IDLE=0, RUN=1, STEP=2, HALTING=3.
Instr_Count  output  CNT_W  instructions retired; wraps at all-ones.

Behaviour:
- Reset (synchronous): State=IDLE, tick counter=0, Phase_Idx=0, div_l=0, Instr_Count=0, halt flag cleared. Phase_En=0, Instr_Done=0, Busy=0.
- Reset has priority over every other input. When asserted mid-instruction, the next cycle shows reset values. No Instr_Done is issued for the aborted instruction.
- Registered state: tick counter cnt (DIV_W), Phase_Idx, div_l, State, Instr_Count.
- Phase_En and Instr_Done are combinational from registers and Stall:
  - fire = (State != IDLE) && (cnt == div_l) && !Stall.
  - Phase_En[Phase_Idx] = fire; all other bits are 0.
  - Instr_Done = fire && (Phase_Idx == NUM_PHASES-1).
- Counting while not IDLE:
  - cnt < div_l: cnt increments.
  - cnt == div_l with Stall=1: cnt and Phase_Idx hold. Stall never drops or skips a phase.
  - On fire: cnt←0. Phase_Idx increments, wrapping NUM_PHASES-1 → 0.
- Instruction completion: Instr_Count increments on Instr_Done.
- Div latching: div_l←Div on entry from IDLE, and on every Instr_Done that continues in RUN. Div changes mid-instruction are ignored.
- Timing: Div=0 gives one phase per cycle (NUM_PHASES cycles per instruction). Div=D gives D+1 cycles per phase. The first Phase_En[0] occurs in the first cycle after leaving IDLE plus div_l cycles.
- Transitions from IDLE:
  - Run=1 → RUN (Run has priority over a simultaneous Step).
  - Step=1 → STEP.
  - Halt_Req has no effect.
- Transitions from RUN:
  - Halt_Req=1, or Run=0 sampled in any cycle → HALTING. The current instruction always finishes.
  - On Instr_Done with Run=1 and Halt_Req=0 → stay in RUN.
- STEP: Step and Run are ignored. On Instr_Done → IDLE.
- HALTING: Run, Step and Halt_Req are ignored. On Instr_Done → IDLE.
- Returning to IDLE: cnt=0, Phase_Idx=0. The last Instr_Done cycle is the final enable.
- Halt_Req and Instr_Done in the same cycle while in RUN → IDLE next cycle. No further enables.
- Stall in IDLE: no effect.

Test Plan:
1. NUM_PHASES=5, Div=0, Run raised at cycle 10 and held:
   - Phase_En = 00001, 00010, 00100, 01000, 10000 on cycles 11–15.
   - Instr_Done high at cycle 15; Instr_Count=1 at cycle 16; Phase_En=00001 again at cycle 16.
2. Div=2, Step pulse at cycle 5:
   - Phase_En[0] at cycle 8, then one enable every 3 cycles; Phase_En[4] and Instr_Done at cycle 20.
   - State returns to IDLE (Busy=0) at cycle 21; Instr_Count=1.
3. Div=0, in RUN, Stall held high for 4 cycles when Phase_Idx=2:
   - Phase_En stays 0 for those 4 cycles; Phase_En=00100 in the first cycle Stall=0.
   - Instr_Done is delayed by exactly 4 cycles; no phase is skipped.
4. Div=1, Halt_Req pulsed during phase 1:
   - State=HALTING; phases 1–4 still issue; Instr_Done fires; State=IDLE next cycle.
   - No Phase_En for the following 20 cycles even though Run stays high.
5. Div changed from 0 to 3 in the middle of an instruction:
   - Remaining phases of that instruction keep 1-cycle spacing; the next instruction uses 4-cycle spacing.
6. Reset asserted for one cycle while Phase_Idx=3 in RUN:
   - Next cycle: State=IDLE, Phase_En=0, Instr_Count=0, Busy=0; no Instr_Done pulse.
   - With Run still high, Phase_En=00001 two cycles after Reset deasserts (Div=0).
